// File: rtl/ram16x8_arbiter_pkg.sv
// ram16x8_arbiter_pkg: shared FSM state encoding and default geometry for the RAM arbiter
package ram16x8_arbiter_pkg;
  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;
  localparam int AW_DEF = 4;
  localparam int DW_DEF = 8;
  localparam int MAX_BURST_DEF = 4;
endpackage

// File: rtl/ram16x8.sv
// ram16x8: synchronous single-port RAM, zero-filled on reset, read data one cycle after the read edge
module ram16x8 #(
  parameter int AW = 4,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cs,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] dout
);
  logic [DW-1:0] mem [2**AW];
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 2**AW; i++) mem[i] <= '0;
      dout <= '0;
    end else if (cs) begin
      if (we) mem[addr] <= din;
      else dout <= mem[addr];
    end
  end
endmodule

// File: rtl/ram16x8_arbiter.sv
// ram16x8_arbiter: two-port burst-capped RAM arbiter; define RAM_ARB_RR_EN for round-robin IDLE ties
module ram16x8_arbiter
  import ram16x8_arbiter_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF,
  parameter int MAX_BURST = MAX_BURST_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          p0_req,
  input  logic          p0_we,
  input  logic [AW-1:0] p0_addr,
  input  logic [DW-1:0] p0_wdata,
  output logic          p0_gnt,
  output logic          p0_rvalid,
  output logic [DW-1:0] p0_rdata,
  input  logic          p1_req,
  input  logic          p1_we,
  input  logic [AW-1:0] p1_addr,
  input  logic [DW-1:0] p1_wdata,
  output logic          p1_gnt,
  output logic          p1_rvalid,
  output logic [DW-1:0] p1_rdata,
  output logic          ram_cs,
  output logic          ram_we,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_din,
  input  logic [DW-1:0] ram_dout
);
  localparam int CW = $clog2(MAX_BURST + 1);
  state_t state;
  logic [CW-1:0] cnt;
  logic [1:0] rq, rd_pend;
  logic [DW-1:0] hold0, hold1;
  logic tie, pref, keep, any, sel;
  assign rq = {p1_req, p0_req};
`ifdef RAM_ARB_RR_EN
  logic ptr;
  assign tie = ~ptr;
  always_ff @(posedge clk) begin
    if (!rst_n) ptr <= 1'b1;
    else if (any) ptr <= sel;
  end
`else
  assign tie = 1'b0;
`endif
  // pref is the port that wins if it asks: the tie winner in IDLE, else the owner until its burst cap
  always_comb begin
    pref = (state == IDLE) ? tie : (state == OWN1);
    keep = rq[pref] && (state == IDLE || cnt < CW'(MAX_BURST) || !rq[~pref]);
    any = rst_n && |rq;
    sel = keep ? pref : ~pref;
  end
  assign p0_gnt = any && !sel;
  assign p1_gnt = any && sel;
  assign ram_cs = any;
  assign ram_we = any && (sel ? p1_we : p0_we);
  assign ram_addr = !any ? '0 : sel ? p1_addr : p0_addr;
  assign ram_din = !any ? '0 : sel ? p1_wdata : p0_wdata;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      rd_pend <= '0;
      hold0 <= '0;
      hold1 <= '0;
    end else begin
      state <= !any ? IDLE : sel ? OWN1 : OWN0;
      cnt <= !any ? '0 : (state == (sel ? OWN1 : OWN0) && cnt < CW'(MAX_BURST)) ? cnt + CW'(1) : CW'(1);
      rd_pend <= {p1_gnt && !p1_we, p0_gnt && !p0_we};
      if (rd_pend[0]) hold0 <= ram_dout;
      if (rd_pend[1]) hold1 <= ram_dout;
    end
  end
  // read data is forwarded straight from the RAM in its valid cycle, then held
  assign p0_rvalid = rst_n && rd_pend[0];
  assign p1_rvalid = rst_n && rd_pend[1];
  assign p0_rdata = !rst_n ? '0 : rd_pend[0] ? ram_dout : hold0;
  assign p1_rdata = !rst_n ? '0 : rd_pend[1] ? ram_dout : hold1;
endmodule

// File: tb/tb_ram16x8_arbiter.sv
// tb_ram16x8_arbiter: directed and random traffic checked every cycle against a behavioural arbiter/RAM model
module tb_ram16x8_arbiter;
  localparam int MB = 4;
  typedef struct packed {logic v; logic we; logic [3:0] a; logic [7:0] d;} cmd_t;
  logic clk = 1'b0, rst_n = 1'b0;
  logic p0_req = 0, p0_we = 0, p1_req = 0, p1_we = 0;
  logic [3:0] p0_addr = 0, p1_addr = 0;
  logic [7:0] p0_wdata = 0, p1_wdata = 0;
  logic p0_gnt, p1_gnt, p0_rvalid, p1_rvalid, ram_cs, ram_we;
  logic [7:0] p0_rdata, p1_rdata, ram_din, ram_dout;
  logic [3:0] ram_addr;
  int errors = 0, checks = 0;
  cmd_t q0[$], q1[$];
  cmd_t cur[2];
  logic gseen[2];
  int gseq[$];
  logic [7:0] rd0[$], rd1[$];
  int owner = -1, run = 0, ptr = 1;
  logic pend[2];
  logic [7:0] pdat[2], last[2], mem[16];

  always #5 clk = ~clk;

  ram16x8_arbiter #(.AW(4), .DW(8), .MAX_BURST(MB)) dut (
    .clk(clk), .rst_n(rst_n),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata),
    .ram_cs(ram_cs), .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din),
    .ram_dout(ram_dout)
  );

  ram16x8 #(.AW(4), .DW(8)) ram (
    .clk(clk), .rst_n(rst_n), .cs(ram_cs), .we(ram_we), .addr(ram_addr),
    .din(ram_din), .dout(ram_dout)
  );

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic cmd_t rd(logic [3:0] a);
    return '{v: 1'b1, we: 1'b0, a: a, d: 8'h00};
  endfunction
  function automatic cmd_t wr(logic [3:0] a, logic [7:0] d);
    return '{v: 1'b1, we: 1'b1, a: a, d: d};
  endfunction
  function automatic cmd_t idl();
    return '0;
  endfunction

  // Behavioural model: decide the grant from the arbitration rules, then compare
  always @(negedge clk) begin
    int g, o;
    logic [1:0] r;
    logic ew;
    logic [3:0] ea;
    logic [7:0] ed;
    r = {p1_req, p0_req};
    gseen[0] = p0_gnt;
    gseen[1] = p1_gnt;
    if (p0_gnt) gseq.push_back(0);
    if (p1_gnt) gseq.push_back(1);
    if (p0_rvalid) rd0.push_back(p0_rdata);
    if (p1_rvalid) rd1.push_back(p1_rdata);
    if (!rst_n) begin
      chk("rst_p0_gnt", p0_gnt, 0);
      chk("rst_p1_gnt", p1_gnt, 0);
      chk("rst_ram_cs", ram_cs, 0);
      chk("rst_ram_we", ram_we, 0);
      chk("rst_p0_rvalid", p0_rvalid, 0);
      chk("rst_p1_rvalid", p1_rvalid, 0);
      chk("rst_p0_rdata", p0_rdata, 0);
      chk("rst_p1_rdata", p1_rdata, 0);
      owner = -1; run = 0; ptr = 1;
      for (int p = 0; p < 2; p++) begin pend[p] = 0; last[p] = 0; pdat[p] = 0; end
      for (int i = 0; i < 16; i++) mem[i] = 0;
    end else begin
      g = -1;
      if (owner < 0) begin
`ifdef RAM_ARB_RR_EN
        if (r == 2'b11) g = 1 - ptr;
`else
        if (r == 2'b11) g = 0;
`endif
        else if (r[0]) g = 0;
        else if (r[1]) g = 1;
      end else begin
        o = owner;
        if (r[o] && run < MB) g = o;
        else if (r[1-o]) g = 1 - o;
        else if (r[o]) g = o;
      end
      ew = (g == 0) ? p0_we : (g == 1) ? p1_we : 1'b0;
      ea = (g == 0) ? p0_addr : (g == 1) ? p1_addr : 4'h0;
      ed = (g == 0) ? p0_wdata : (g == 1) ? p1_wdata : 8'h00;
      chk("p0_gnt", p0_gnt, g == 0);
      chk("p1_gnt", p1_gnt, g == 1);
      chk("ram_cs", ram_cs, g >= 0);
      chk("ram_we", ram_we, ew);
      chk("ram_addr", ram_addr, ea);
      chk("ram_din", ram_din, ed);
      chk("p0_rvalid", p0_rvalid, pend[0]);
      chk("p1_rvalid", p1_rvalid, pend[1]);
      chk("p0_rdata", p0_rdata, pend[0] ? pdat[0] : last[0]);
      chk("p1_rdata", p1_rdata, pend[1] ? pdat[1] : last[1]);
      for (int p = 0; p < 2; p++) begin
        if (pend[p]) last[p] = pdat[p];
        pend[p] = 0;
      end
      if (g >= 0) begin
        if (ew) mem[ea] = ed;
        else begin pdat[g] = mem[ea]; pend[g] = 1; end
        run = (g == owner) ? (run < MB ? run + 1 : 1) : 1;
        owner = g;
        ptr = g;
      end else begin
        owner = -1;
        run = 0;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    if (!cur[0].v || gseen[0]) cur[0] = q0.size() > 0 ? q0.pop_front() : idl();
    if (!cur[1].v || gseen[1]) cur[1] = q1.size() > 0 ? q1.pop_front() : idl();
    p0_req = cur[0].v; p0_we = cur[0].we; p0_addr = cur[0].a; p0_wdata = cur[0].d;
    p1_req = cur[1].v; p1_we = cur[1].we; p1_addr = cur[1].a; p1_wdata = cur[1].d;
  endtask

  task automatic run_phase(string name);
    bit done = 0;
    for (int i = 0; i < 400 && !done; i++) begin
      if (q0.size() == 0 && q1.size() == 0 && !cur[0].v && !cur[1].v) done = 1;
      else step();
    end
    if (!done) chk({name, "_timeout"}, 0, 1);
    repeat (3) step();
  endtask

  task automatic clear_logs();
    gseq.delete();
    rd0.delete();
    rd1.delete();
  endtask

  task automatic chk_seq(string name, int e[$]);
    chk({name, "_len"}, gseq.size(), e.size());
    for (int i = 0; i < e.size() && i < gseq.size(); i++) chk({name, "_gnt"}, gseq[i], e[i]);
  endtask

  task automatic chk_rd(string name, logic [7:0] got[$], int n, logic [7:0] v);
    chk({name, "_count"}, got.size(), n);
    foreach (got[i]) chk({name, "_data"}, got[i], v);
  endtask

  initial begin
    int e[$];
    cur[0] = '0; cur[1] = '0;
    gseen[0] = 0; gseen[1] = 0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    // Simultaneous first requests after reset, then a lone p0 grant, then a second tie
    clear_logs();
    q0 = '{wr(4'd1, 8'h11), idl(), wr(4'd3, 8'h33)};
    q1 = '{wr(4'd2, 8'h22)};
    run_phase("tie1");
    e = '{0, 1, 0};
    chk_seq("tie1", e);
    clear_logs();
    q0 = '{wr(4'd6, 8'h66)};
    q1 = '{wr(4'd7, 8'h77)};
    run_phase("tie2");
`ifdef RAM_ARB_RR_EN
    e = '{1, 0};
`else
    e = '{0, 1};
`endif
    chk_seq("tie2", e);
    // Unwritten address reads back zero
    clear_logs();
    q0 = '{rd(4'd0)};
    run_phase("rd0");
    e = '{0};
    chk_seq("rd0", e);
    chk_rd("rd0_p0", rd0, 1, 8'h00);
    // Write then read the same address on consecutive cycles
    clear_logs();
    q0 = '{wr(4'd4, 8'hAA), rd(4'd4)};
    run_phase("wr_rd");
    e = '{0, 0};
    chk_seq("wr_rd", e);
    chk_rd("wr_rd_p0", rd0, 1, 8'hAA);
    // Burst cap: p0 streams reads, p1 write waits four grants
    clear_logs();
    q0 = '{rd(4'd4), rd(4'd4), rd(4'd4), rd(4'd4), rd(4'd4), rd(4'd4), rd(4'd4), rd(4'd4)};
    q1 = '{idl(), wr(4'd5, 8'hBB)};
    run_phase("burst");
    e = '{0, 0, 0, 0, 1, 0, 0, 0, 0};
    chk_seq("burst", e);
    chk_rd("burst_p0", rd0, 8, 8'hAA);
    // Alternating-port reads every cycle
    clear_logs();
    q0 = '{rd(4'd4), idl(), rd(4'd4), idl(), rd(4'd4)};
    q1 = '{idl(), rd(4'd5), idl(), rd(4'd5), idl(), rd(4'd5)};
    run_phase("alt");
    e = '{0, 1, 0, 1, 0, 1};
    chk_seq("alt", e);
    chk_rd("alt_p0", rd0, 3, 8'hAA);
    chk_rd("alt_p1", rd1, 3, 8'hBB);
    // Reset lands the cycle after a read grant: the read is dropped
    clear_logs();
    q0 = '{rd(4'd4)};
    step();
    step();
    rst_n = 1'b0;
    @(negedge clk);
    #1;
    chk("midrst_p0_rvalid", p0_rvalid, 0);
    chk("midrst_ram_cs", ram_cs, 0);
    chk("midrst_p0_rdata", p0_rdata, 0);
    step();
    rst_n = 1'b1;
    repeat (2) step();
    chk("midrst_no_rvalid", rd0.size(), 0);
    clear_logs();
    q0 = '{rd(4'd4)};
    run_phase("post_rst");
    e = '{0};
    chk_seq("post_rst", e);
    chk_rd("post_rst_p0", rd0, 1, 8'h00);
    // Random traffic against the model
    for (int i = 0; i < 600; i++) begin
      if (q0.size() == 0 && $urandom_range(0, 3) != 0)
        q0.push_back($urandom_range(0, 4) == 0 ? idl() :
          '{v: 1'b1, we: 1'($urandom_range(0, 1)), a: 4'($urandom_range(0, 7)), d: 8'($urandom)});
      if (q1.size() == 0 && $urandom_range(0, 3) != 0)
        q1.push_back($urandom_range(0, 4) == 0 ? idl() :
          '{v: 1'b1, we: 1'($urandom_range(0, 1)), a: 4'($urandom_range(0, 7)), d: 8'($urandom)});
      step();
    end
    run_phase("random");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end
endmodule
